// File: rtl/fma_issue_ctrl_pkg.sv
// ============================================================================
// fma_issue_ctrl_pkg : shared width, rounding-mode codes and clog2 helper
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

package fma_issue_ctrl_pkg;

  localparam int WIDTH = 64;

  localparam logic [1:0] RND_RZ  = 2'b00;
  localparam logic [1:0] RND_RN  = 2'b01;
  localparam logic [1:0] RND_RNE = 2'b10;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fma_issue_ctrl_if.sv
// ============================================================================
// fma_issue_ctrl_if : operand, datapath and result handshake bundle
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

interface fma_issue_ctrl_if #(
  parameter int WIDTH = fma_issue_ctrl_pkg::WIDTH
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [WIDTH-1:0] in_c;
  logic [1:0]       in_rnd;

  logic [WIDTH-1:0] fma_a;
  logic [WIDTH-1:0] fma_b;
  logic [WIDTH-1:0] fma_c;
  logic [1:0]       fma_rnd;
  logic [WIDTH-1:0] fma_result;

  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic             busy;

  modport slave (
    input  in_valid, in_a, in_b, in_c, in_rnd, fma_result, out_ready,
    output in_ready, fma_a, fma_b, fma_c, fma_rnd, out_valid, out_result, busy
  );

  modport master (
    output in_valid, in_a, in_b, in_c, in_rnd, fma_result, out_ready,
    input  in_ready, fma_a, fma_b, fma_c, fma_rnd, out_valid, out_result, busy
  );

endinterface

`default_nettype wire

// File: rtl/fma_issue_ctrl_sync_fifo.sv
// ============================================================================
// sync_fifo : single-clock FIFO with separate occupancy count
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

module sync_fifo
  import fma_issue_ctrl_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push_i,
  input  logic [DATA_W-1:0]       data_i,
  input  logic                    pop_i,
  output logic [DATA_W-1:0]       data_o,
  output logic                    full_o,
  output logic                    empty_o,
  output logic [clog2(DEPTH):0]   count_o
);

  localparam int AW = clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q;
  logic [AW-1:0]     rd_ptr_q;
  logic [AW:0]       count_q;
  logic [AW:0]       count_d;
  logic              do_push;
  logic              do_pop;

  // Pointers wrap naturally at DEPTH; the count disambiguates full from empty.
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_comb begin
    count_d = count_q;
    if (do_push && !do_pop) begin
      count_d = count_q + (AW+1)'(1);
    end else if (do_pop && !do_push) begin
      count_d = count_q - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      count_q <= count_d;
    end
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

endmodule

`default_nettype wire

// File: rtl/fma_issue_ctrl.sv
// ============================================================================
// fma_issue_ctrl : credit-gated operand issue and result capture around fpfma
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

module fma_issue_ctrl #(
  parameter int WIDTH     = fma_issue_ctrl_pkg::WIDTH,
  parameter int IN_DEPTH  = 4,
  parameter int OUT_DEPTH = 4,
  parameter int FMA_LAT   = 1
) (
  input  logic           clk,
  input  logic           rst,
  fma_issue_ctrl_if.slave bus
);

  import fma_issue_ctrl_pkg::*;

  localparam int IN_W   = 3 * WIDTH + 2;
  localparam int IN_CW  = clog2(IN_DEPTH) + 1;
  localparam int OUT_CW = clog2(OUT_DEPTH) + 1;
  localparam int CRED_W = clog2(OUT_DEPTH) + 1;

  logic [IN_W-1:0]   in_wdata;
  logic [IN_W-1:0]   in_rdata;
  logic              in_full;
  logic              in_empty;
  logic              in_push;
  logic [IN_CW-1:0]  in_count;

  logic              out_full;
  logic              out_empty;
  logic              out_pop;
  logic              out_push;
  logic [OUT_CW-1:0] out_count;

  logic              issue;
  logic              capture;
  logic [CRED_W-1:0] cred_q;
  logic [CRED_W-1:0] cred_d;
  logic [FMA_LAT-1:0] lat_q;
  logic [FMA_LAT-1:0] lat_d;

  logic [WIDTH-1:0]  fma_a_q;
  logic [WIDTH-1:0]  fma_b_q;
  logic [WIDTH-1:0]  fma_c_q;
  logic [1:0]        fma_rnd_q;

  assign in_wdata = {bus.in_a, bus.in_b, bus.in_c, bus.in_rnd};
  assign in_push  = bus.in_valid & bus.in_ready;

  sync_fifo #(
    .DATA_W (IN_W),
    .DEPTH  (IN_DEPTH)
  ) u_in_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (in_push),
    .data_i  (in_wdata),
    .pop_i   (issue),
    .data_o  (in_rdata),
    .full_o  (in_full),
    .empty_o (in_empty),
    .count_o (in_count)
  );

  // A credit stands for one guaranteed output slot, so capture never stalls.
  assign issue   = ~in_empty & (cred_q != '0);
  assign capture = lat_q[FMA_LAT-1];
  assign out_pop = ~out_empty & bus.out_ready;
  assign out_push = capture & ~out_full;

  sync_fifo #(
    .DATA_W (WIDTH),
    .DEPTH  (OUT_DEPTH)
  ) u_out_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (out_push),
    .data_i  (bus.fma_result),
    .pop_i   (out_pop),
    .data_o  (bus.out_result),
    .full_o  (out_full),
    .empty_o (out_empty),
    .count_o (out_count)
  );

  always_comb begin
    cred_d = cred_q;
    if (issue && !out_pop) begin
      cred_d = cred_q - CRED_W'(1);
    end else if (out_pop && !issue) begin
      cred_d = cred_q + CRED_W'(1);
    end
    lat_d = FMA_LAT'({lat_q, issue});
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cred_q    <= CRED_W'(OUT_DEPTH);
      lat_q     <= '0;
      fma_a_q   <= '0;
      fma_b_q   <= '0;
      fma_c_q   <= '0;
      fma_rnd_q <= '0;
    end else begin
      cred_q <= cred_d;
      lat_q  <= lat_d;
      if (issue) begin
        {fma_a_q, fma_b_q, fma_c_q, fma_rnd_q} <= in_rdata;
      end
    end
  end

  assign bus.in_ready  = rst & ~in_full;
  assign bus.fma_a     = fma_a_q;
  assign bus.fma_b     = fma_b_q;
  assign bus.fma_c     = fma_c_q;
  assign bus.fma_rnd   = fma_rnd_q;
  assign bus.out_valid = ~out_empty;
  assign bus.busy      = (in_count != '0) | (|lat_q) | (out_count != '0);

endmodule

`default_nettype wire

// File: tb/tb_fma_issue_ctrl.sv
// ============================================================================
// tb_fma_issue_ctrl : directed checks on a latency-1 and a latency-3 instance
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_fma_issue_ctrl;

  localparam int W = 64;
  localparam logic [W-1:0] B_OP = 64'h4000000000000000;  // 2.0
  localparam logic [W-1:0] C_OP = 64'h3FE0000000000000;  // 0.5

  logic clk;
  logic rst;
  int   total;
  int   bad;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  fma_issue_ctrl_if #(.WIDTH(W)) ifa ();
  fma_issue_ctrl_if #(.WIDTH(W)) ifb ();

  fma_issue_ctrl #(.WIDTH(W), .IN_DEPTH(4), .OUT_DEPTH(4), .FMA_LAT(1)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (ifa)
  );

  fma_issue_ctrl #(.WIDTH(W), .IN_DEPTH(4), .OUT_DEPTH(4), .FMA_LAT(3)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (ifb)
  );

  // Datapath models: combinational for latency 1, two extra stages for latency 3.
  assign ifa.fma_result = $realtobits($bitstoreal(ifa.fma_a) * $bitstoreal(ifa.fma_b)
                                      + $bitstoreal(ifa.fma_c));

  logic [W-1:0] pa1, pb1, pc1, pa2, pb2, pc2;
  always @(posedge clk) begin
    pa1 <= ifb.fma_a;  pb1 <= ifb.fma_b;  pc1 <= ifb.fma_c;
    pa2 <= pa1;        pb2 <= pb1;        pc2 <= pc1;
  end
  assign ifb.fma_result = $realtobits($bitstoreal(pa2) * $bitstoreal(pb2) + $bitstoreal(pc2));

  function automatic logic [W-1:0] op_a(input int k);
    return $realtobits(real'(k + 1));
  endfunction

  function automatic logic [W-1:0] exp_res(input int k);
    return $realtobits(2.0 * real'(k + 1) + 0.5);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input int k, input logic [1:0] rnd);
    ifa.in_valid = 1'b1; ifa.in_a = op_a(k); ifa.in_b = B_OP; ifa.in_c = C_OP; ifa.in_rnd = rnd;
  endtask

  task automatic drive_b(input int k);
    ifb.in_valid = 1'b1; ifb.in_a = op_a(k); ifb.in_b = B_OP; ifb.in_c = C_OP; ifb.in_rnd = 2'b01;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1 rst = 1'b0;
    #6;
    total++; if (ifa.in_ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready: got %b want 0", ifa.in_ready); end
    total++; if (ifa.out_valid !== 1'b0 || ifa.busy !== 1'b0) begin bad++; $display("FAIL rst_valid_busy: got %b%b want 00", ifa.out_valid, ifa.busy); end
    total++; if (ifa.out_result !== '0 || ifa.fma_a !== '0 || ifa.fma_rnd !== 2'b00) begin bad++; $display("FAIL rst_data: got %h %h want 0", ifa.out_result, ifa.fma_a); end
    #5 rst = 1'b1;
    step();
    total++; if (ifa.in_ready !== 1'b1 || ifb.in_ready !== 1'b1) begin bad++; $display("FAIL rel_in_ready: got %b%b want 11", ifa.in_ready, ifb.in_ready); end
    total++; if (dut_a.cred_q !== 3'd4) begin bad++; $display("FAIL rst_credits: got %0d want 4", dut_a.cred_q); end
  endtask

  task automatic test_single();
    ifa.in_valid = 1'b1; ifa.in_a = 64'h3FF0000000000000; ifa.in_b = 64'h4000000000000000;
    ifa.in_c = 64'h4008000000000000; ifa.in_rnd = 2'b01;
    step();
    ifa.in_valid = 1'b0;
    total++; if (ifa.fma_a !== '0 || ifa.busy !== 1'b1) begin bad++; $display("FAIL single_push: fma_a %h busy %b want 0 1", ifa.fma_a, ifa.busy); end
    step();
    total++; if (ifa.fma_a !== 64'h3FF0000000000000 || ifa.fma_rnd !== 2'b01) begin bad++; $display("FAIL single_issue: got %h %b want 3ff0000000000000 01", ifa.fma_a, ifa.fma_rnd); end
    total++; if (ifa.out_valid !== 1'b0) begin bad++; $display("FAIL single_early: got %b want 0", ifa.out_valid); end
    step();
    total++; if (ifa.out_valid !== 1'b1 || ifa.out_result !== 64'h4014000000000000) begin bad++; $display("FAIL single_result: got %b %h want 1 4014000000000000", ifa.out_valid, ifa.out_result); end
    ifa.out_ready = 1'b1;
    step();
    total++; if (ifa.out_valid !== 1'b0 || ifa.busy !== 1'b0) begin bad++; $display("FAIL single_drain: got %b%b want 00", ifa.out_valid, ifa.busy); end
    ifa.out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    ifa.out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (i < 8) drive_a(i, 2'b01); else ifa.in_valid = 1'b0;
      step();
      if (i < 8) begin
        total++; if (ifa.in_ready !== 1'b1) begin bad++; $display("FAIL b2b_in_ready[%0d]: got %b want 1", i, ifa.in_ready); end
      end
      if (i >= 2) begin
        total++;
        if (ifa.out_valid !== 1'b1 || ifa.out_result !== exp_res(i - 2)) begin
          bad++; $display("FAIL b2b_result[%0d]: got %b %h want 1 %h", i - 2, ifa.out_valid, ifa.out_result, exp_res(i - 2));
        end
      end
    end
    step();
    total++; if (ifa.out_valid !== 1'b0 || ifa.busy !== 1'b0) begin bad++; $display("FAIL b2b_idle: got %b%b want 00", ifa.out_valid, ifa.busy); end
    ifa.out_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    int k;
    int t;
    logic acc;
    k = 0;
    ifa.out_ready = 1'b0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      if (k < 10) drive_a(20 + k, 2'b01); else ifa.in_valid = 1'b0;
      acc = ifa.in_ready & ifa.in_valid;
      step();
      if (acc) k++;
    end
    ifa.in_valid = 1'b0;
    total++; if (k != 8) begin bad++; $display("FAIL bp_accepted: got %0d want 8", k); end
    total++; if (ifa.in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready: got %b want 0", ifa.in_ready); end
    total++; if (dut_a.cred_q !== 3'd0) begin bad++; $display("FAIL bp_credits: got %0d want 0", dut_a.cred_q); end
    total++; if (ifa.out_valid !== 1'b1 || ifa.out_result !== exp_res(20)) begin bad++; $display("FAIL bp_head: got %b %h want 1 %h", ifa.out_valid, ifa.out_result, exp_res(20)); end
    ifa.out_ready = 1'b1;
    for (int j = 0; j < 8; j++) begin
      t = 0;
      while (ifa.out_valid !== 1'b1 && t < 10) begin step(); t++; end
      total++;
      if (ifa.out_valid !== 1'b1 || ifa.out_result !== exp_res(20 + j)) begin
        bad++; $display("FAIL bp_drain[%0d]: got %b %h want 1 %h", j, ifa.out_valid, ifa.out_result, exp_res(20 + j));
      end
      step();
    end
    step();
    total++; if (ifa.busy !== 1'b0 || dut_a.cred_q !== 3'd4) begin bad++; $display("FAIL bp_end: busy %b credits %0d want 0 4", ifa.busy, dut_a.cred_q); end
    ifa.out_ready = 1'b0;
  endtask

  task automatic test_rounding();
    logic [1:0] rv [3];
    rv[0] = 2'b00; rv[1] = 2'b10; rv[2] = 2'b11;
    ifa.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i < 3) drive_a(40 + i, rv[i]); else ifa.in_valid = 1'b0;
      step();
      if (i >= 1) begin
        total++;
        if (ifa.fma_rnd !== rv[i-1] || ifa.fma_a !== op_a(40 + i - 1)) begin
          bad++; $display("FAIL rnd_pass[%0d]: got %b %h want %b %h", i - 1, ifa.fma_rnd, ifa.fma_a, rv[i-1], op_a(40 + i - 1));
        end
      end
    end
    step(); step(); step();
    ifa.out_ready = 1'b0;
    total++; if (ifa.busy !== 1'b0) begin bad++; $display("FAIL rnd_idle: got %b want 0", ifa.busy); end
  endtask

  task automatic test_lat3();
    int t;
    ifb.out_ready = 1'b0;
    drive_b(60);
    step();
    ifb.in_valid = 1'b0;
    step();
    total++; if (ifb.fma_a !== op_a(60)) begin bad++; $display("FAIL l3_issue: got %h want %h", ifb.fma_a, op_a(60)); end
    step(); step();
    total++; if (ifb.out_valid !== 1'b0) begin bad++; $display("FAIL l3_early: got %b want 0", ifb.out_valid); end
    step();
    total++; if (ifb.out_valid !== 1'b1 || ifb.out_result !== exp_res(60)) begin bad++; $display("FAIL l3_capture: got %b %h want 1 %h", ifb.out_valid, ifb.out_result, exp_res(60)); end
    ifb.out_ready = 1'b1;
    step();
    ifb.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin drive_b(70 + i); step(); end
    ifb.in_valid = 1'b0;
    repeat (6) step();
    total++; if (dut_b.cred_q !== 3'd0 || ifb.out_result !== exp_res(70)) begin bad++; $display("FAIL l3_full: credits %0d head %h want 0 %h", dut_b.cred_q, ifb.out_result, exp_res(70)); end
    ifb.out_ready = 1'b1;
    step();
    total++; if (dut_b.cred_q !== 3'd1 || ifb.out_result !== exp_res(71)) begin bad++; $display("FAIL l3_pop: credits %0d head %h want 1 %h", dut_b.cred_q, ifb.out_result, exp_res(71)); end
    step();
    total++; if (dut_b.cred_q !== 3'd1 || ifb.fma_a !== op_a(74)) begin bad++; $display("FAIL l3_pop_issue: credits %0d fma_a %h want 1 %h", dut_b.cred_q, ifb.fma_a, op_a(74)); end
    for (int j = 2; j < 5; j++) begin
      t = 0;
      while (ifb.out_valid !== 1'b1 && t < 10) begin step(); t++; end
      total++;
      if (ifb.out_valid !== 1'b1 || ifb.out_result !== exp_res(70 + j)) begin
        bad++; $display("FAIL l3_drain[%0d]: got %b %h want 1 %h", j, ifb.out_valid, ifb.out_result, exp_res(70 + j));
      end
      step();
    end
    ifb.out_ready = 1'b0;
    step(); step();
    total++; if (ifb.busy !== 1'b0 || dut_b.cred_q !== 3'd4) begin bad++; $display("FAIL l3_end: busy %b credits %0d want 0 4", ifb.busy, dut_b.cred_q); end
  endtask

  task automatic test_async_reset();
    int t;
    logic stale;
    ifb.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin drive_b(80 + i); step(); end
    ifb.in_valid = 1'b0;
    total++; if (ifb.busy !== 1'b1 || ifb.out_valid !== 1'b1) begin bad++; $display("FAIL ar_pre: got %b%b want 11", ifb.busy, ifb.out_valid); end
    rst = 1'b0;
    #1;
    total++; if (ifb.in_ready !== 1'b0 || ifb.out_valid !== 1'b0 || ifb.busy !== 1'b0) begin bad++; $display("FAIL ar_flags: got %b%b%b want 000", ifb.in_ready, ifb.out_valid, ifb.busy); end
    total++; if (ifb.out_result !== '0 || ifb.fma_a !== '0 || ifb.fma_rnd !== 2'b00) begin bad++; $display("FAIL ar_data: got %h %h %b want 0", ifb.out_result, ifb.fma_a, ifb.fma_rnd); end
    total++; if (dut_b.cred_q !== 3'd4) begin bad++; $display("FAIL ar_credits: got %0d want 4", dut_b.cred_q); end
    #2 rst = 1'b1;
    #1;
    total++; if (ifb.in_ready !== 1'b1) begin bad++; $display("FAIL ar_release: got %b want 1", ifb.in_ready); end
    stale = 1'b0;
    for (int i = 0; i < 6; i++) begin step(); if (ifb.out_valid !== 1'b0) stale = 1'b1; end
    total++; if (stale !== 1'b0) begin bad++; $display("FAIL ar_stale: got %b want 0", stale); end
    drive_b(90);
    step();
    ifb.in_valid = 1'b0;
    t = 0;
    while (ifb.out_valid !== 1'b1 && t < 10) begin step(); t++; end
    total++; if (ifb.out_valid !== 1'b1 || ifb.out_result !== exp_res(90)) begin bad++; $display("FAIL ar_fresh: got %b %h want 1 %h", ifb.out_valid, ifb.out_result, exp_res(90)); end
    ifb.out_ready = 1'b1;
    step();
    ifb.out_ready = 1'b0;
    total++; if (ifb.busy !== 1'b0) begin bad++; $display("FAIL ar_idle: got %b want 0", ifb.busy); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    ifa.in_valid = 1'b0; ifa.in_a = '0; ifa.in_b = '0; ifa.in_c = '0; ifa.in_rnd = 2'b00; ifa.out_ready = 1'b0;
    ifb.in_valid = 1'b0; ifb.in_a = '0; ifb.in_b = '0; ifb.in_c = '0; ifb.in_rnd = 2'b00; ifb.out_ready = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_rounding();
    test_lat3();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
